// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the 1-cycle instruction SRAM, and
// holds a branch redirect that arrives while fetch is stalled until the stall clears.
module if_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'hbfc0_0000,
   parameter int          CNT_W    = 32,
   parameter int          STALL_W  = 6
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [STALL_W-1:0] i_stall,
   input  logic [32:0]        i_br_bus,
   output logic [32:0]        o_if_to_id_bus,
   output logic               o_inst_sram_en,
   output logic [3:0]         o_inst_sram_wen,
   output logic [31:0]        o_inst_sram_addr,
   output logic [31:0]        o_inst_sram_wdata,
   output logic [CNT_W-1:0]   o_fetch_cnt,
   output logic               o_br_pend
);

   localparam logic STOP = 1'b1;

   typedef enum logic {S_IDLE = 1'b0, S_PEND = 1'b1} br_state_t;

   br_state_t        r_state;
   br_state_t        w_state_nxt;
   logic [31:0]      r_pc;
   logic             r_ce;
   logic [31:0]      r_br_tgt;
   logic [CNT_W-1:0] r_fetch_cnt;

   logic        w_stop;
   logic        w_br_e;
   logic [31:0] w_br_addr;
   logic [31:0] w_next_pc;
   logic        w_br_pend;
   logic        w_unused_stall;

   assign w_stop         = (i_stall[0] == STOP);
   assign w_br_e         = i_br_bus[32];
   assign w_br_addr      = i_br_bus[31:0];
   assign w_unused_stall = ^i_stall[STALL_W-1:1];

   // A held target outranks a live br_e: on release they are the same branch.
   always_comb begin
      w_next_pc = r_pc + 32'd4;
      if (w_br_pend)
         w_next_pc = r_br_tgt;
      else if (w_br_e)
         w_next_pc = w_br_addr;
   end

   always_ff @(posedge clk) begin
      if (rst)
         r_state <= S_IDLE;
      else
         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      if (!w_stop)
         w_state_nxt = S_IDLE;
      else if (w_br_e)
         w_state_nxt = S_PEND;
   end

   always_comb begin
      w_br_pend = 1'b0;
      if (r_state == S_PEND)
         w_br_pend = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_pc        <= RESET_PC - 32'd4;
         r_ce        <= 1'b0;
         r_br_tgt    <= 32'd0;
         r_fetch_cnt <= '0;
      end else begin
         r_ce <= 1'b1;
         if (!w_stop) begin
            r_pc <= w_next_pc;
            if (r_ce)
               r_fetch_cnt <= r_fetch_cnt + CNT_W'(1);
         end else if (w_br_e) begin
            r_br_tgt <= w_br_addr;
         end
      end
   end

   // PC is held through stalls so the SRAM re-reads the same word.
   assign o_inst_sram_en    = r_ce;
   assign o_inst_sram_addr  = r_pc;
   assign o_inst_sram_wen   = 4'b0000;
   assign o_inst_sram_wdata = 32'd0;
   assign o_if_to_id_bus    = {r_ce, r_pc};
   assign o_fetch_cnt       = r_fetch_cnt;
   assign o_br_pend         = w_br_pend;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed scenarios plus random stalls/branches/resets,
// compared every cycle against a behavioural model of the fetch rules.
module tb_if_fetch_unit;

   localparam logic [31:0] RESET_PC = 32'hbfc0_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [5:0]  stall = '0;
   logic [32:0] br_bus = '0;
   logic [32:0] if_to_id_bus;
   logic        inst_sram_en;
   logic [3:0]  inst_sram_wen;
   logic [31:0] inst_sram_addr;
   logic [31:0] inst_sram_wdata;
   logic [31:0] fetch_cnt;
   logic        br_pend;

   int total = 0;
   int bad   = 0;

   // model state
   logic [31:0] m_pc;
   logic        m_ce;
   bit          m_has_tgt;
   logic [31:0] m_tgt;
   logic [31:0] m_cnt;

   if_fetch_unit #(.RESET_PC(RESET_PC), .CNT_W(32), .STALL_W(6)) dut (
      .clk               (clk),
      .rst               (rst),
      .i_stall           (stall),
      .i_br_bus          (br_bus),
      .o_if_to_id_bus    (if_to_id_bus),
      .o_inst_sram_en    (inst_sram_en),
      .o_inst_sram_wen   (inst_sram_wen),
      .o_inst_sram_addr  (inst_sram_addr),
      .o_inst_sram_wdata (inst_sram_wdata),
      .o_fetch_cnt       (fetch_cnt),
      .o_br_pend         (br_pend)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Fetch rules: the PC moves only when not stalled, to the held target if one
   // exists, else to a live branch, else sequentially; a stalled branch is remembered.
   task automatic model(input logic r, input logic stop, input logic be, input logic [31:0] ba);
      logic [31:0] target;
      if (r) begin
         m_pc = RESET_PC - 32'd4; m_ce = 1'b0; m_has_tgt = 0; m_tgt = 0; m_cnt = 0;
      end else begin
         target = m_has_tgt ? m_tgt : (be ? ba : m_pc + 32'd4);
         if (!stop) begin
            if (m_ce) m_cnt = m_cnt + 1;
            m_pc = target;
            m_has_tgt = 0;
         end else if (be) begin
            m_has_tgt = 1;
            m_tgt = ba;
         end
         m_ce = 1'b1;
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, "_addr"}, 64'(inst_sram_addr), 64'(m_pc));
      chk({tag, "_bus"}, 64'(if_to_id_bus), 64'({m_ce, m_pc}));
      chk({tag, "_en"}, 64'(inst_sram_en), 64'(m_ce));
      chk({tag, "_cnt"}, 64'(fetch_cnt), 64'(m_cnt));
      chk({tag, "_pend"}, 64'(br_pend), 64'(m_has_tgt));
      chk({tag, "_wen"}, 64'(inst_sram_wen), 64'(0));
      chk({tag, "_wdata"}, 64'(inst_sram_wdata), 64'(0));
   endtask

   task automatic step(input string tag, input logic r, input logic [5:0] st,
                       input logic be, input logic [31:0] ba);
      @(negedge clk);
      rst = r; stall = st; br_bus = {be, ba};
      @(posedge clk);
      model(r, st[0], be, ba);
      #1;
      check_all(tag);
   endtask

   task automatic do_reset();
      step("rst", 1'b1, 6'd0, 1'b0, 32'd0);
      step("rst", 1'b1, 6'd0, 1'b0, 32'd0);
   endtask

   initial begin
      logic [31:0] ra;
      logic        rb;
      logic [5:0]  rs;
      logic        rr;

      do_reset();
      chk("reset_bus", 64'(if_to_id_bus), 64'(33'h0_bfbffffc));
      chk("reset_en", 64'(inst_sram_en), 64'(0));

      // sequential fetch
      step("t1", 1'b0, 6'd0, 1'b0, 32'd0);
      chk("t1_a0", 64'(inst_sram_addr), 64'(32'hbfc00000));
      step("t1", 1'b0, 6'd0, 1'b0, 32'd0);
      chk("t1_a1", 64'(inst_sram_addr), 64'(32'hbfc00004));
      step("t1", 1'b0, 6'd0, 1'b0, 32'd0);
      chk("t1_a2", 64'(inst_sram_addr), 64'(32'hbfc00008));
      step("t1", 1'b0, 6'd0, 1'b0, 32'd0);
      step("t1", 1'b0, 6'd0, 1'b0, 32'd0);

      // stall at bfc00010
      for (int i = 0; i < 3; i++) begin
         step("t2", 1'b0, 6'd1, 1'b0, 32'd0);
         chk("t2_hold", 64'(inst_sram_addr), 64'(32'hbfc00010));
      end
      step("t2", 1'b0, 6'd0, 1'b0, 32'd0);
      chk("t2_rel", 64'(inst_sram_addr), 64'(32'hbfc00014));

      // branch with delay slot at bfc00008
      do_reset();
      for (int i = 0; i < 3; i++) step("t3", 1'b0, 6'd0, 1'b0, 32'd0);
      chk("t3_slot", 64'(inst_sram_addr), 64'(32'hbfc00008));
      step("t3", 1'b0, 6'd0, 1'b1, 32'hbfc00100);
      chk("t3_tgt", 64'(inst_sram_addr), 64'(32'hbfc00100));

      // branch latched during stall
      step("t4", 1'b0, 6'd1, 1'b1, 32'hbfc00200);
      chk("t4_pend", 64'(br_pend), 64'(1));
      step("t4", 1'b0, 6'd1, 1'b0, 32'd0);
      step("t4", 1'b0, 6'd1, 1'b0, 32'd0);
      chk("t4_hold", 64'(inst_sram_addr), 64'(32'hbfc00100));
      step("t4", 1'b0, 6'd0, 1'b0, 32'd0);
      chk("t4_rel", 64'(inst_sram_addr), 64'(32'hbfc00200));
      chk("t4_clr", 64'(br_pend), 64'(0));

      // latest branch during stall wins
      step("t5", 1'b0, 6'd1, 1'b1, 32'hbfc00300);
      step("t5", 1'b0, 6'd1, 1'b1, 32'hbfc00400);
      step("t5", 1'b0, 6'd0, 1'b0, 32'd0);
      chk("t5_rel", 64'(inst_sram_addr), 64'(32'hbfc00400));

      // held target beats a live br_e on release
      step("t5b", 1'b0, 6'd1, 1'b1, 32'hbfc00500);
      step("t5b", 1'b0, 6'd0, 1'b1, 32'hbfc00600);
      chk("t5b_rel", 64'(inst_sram_addr), 64'(32'hbfc00500));

      // reset discards a pending branch
      step("t6", 1'b0, 6'd1, 1'b1, 32'hbfc00700);
      step("t6", 1'b1, 6'd1, 1'b1, 32'hbfc00800);
      chk("t6_bus", 64'(if_to_id_bus), 64'(33'h0_bfbffffc));
      chk("t6_cnt", 64'(fetch_cnt), 64'(0));
      chk("t6_pend", 64'(br_pend), 64'(0));
      step("t6", 1'b0, 6'd0, 1'b0, 32'd0);
      chk("t6_pc", 64'(inst_sram_addr), 64'(32'hbfc00000));

      // PC wrap and misaligned target
      step("wrap", 1'b0, 6'd0, 1'b1, 32'hffff_fffc);
      step("wrap", 1'b0, 6'd0, 1'b0, 32'd0);
      chk("wrap_zero", 64'(inst_sram_addr), 64'(0));
      step("mis", 1'b0, 6'd0, 1'b1, 32'h0000_1235);
      chk("mis_addr", 64'(inst_sram_addr), 64'(32'h0000_1235));

      // random traffic
      for (int i = 0; i < 600; i++) begin
         rr = ($urandom_range(0, 99) < 2);
         rs = 6'($urandom_range(0, 63));
         rs[0] = ($urandom_range(0, 99) < 35);
         rb = ($urandom_range(0, 99) < 20);
         ra = $urandom;
         if ($urandom_range(0, 3) != 0) ra[1:0] = 2'b00;
         step("rnd", rr, rs, rb, ra);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
